// File: rtl/booth_sequencer_if.sv
// Handshake and control bundle between a Booth multiplier datapath (plus its
// requester) and the booth_sequencer control FSM.
//   master: requester/datapath side, drives start and Q, observes the strobes
//   slave : sequencer side, observes start and Q, drives the strobes
interface booth_sequencer_if #(
  parameter int NB = 4
);
  localparam int W = $clog2(NB) + 1;

  logic          start;
  logic [NB-1:0] q;
  logic          load;
  logic          arithmetic;
  logic          shift;
  logic [W-1:0]  shmnt;
  logic          busy;
  logic          done;
  logic [W-1:0]  op_count;

  modport master (
    output start, q,
    input  load, arithmetic, shift, shmnt, busy, done, op_count
  );

  modport slave (
    input  start, q,
    output load, arithmetic, shift, shmnt, busy, done, op_count
  );
endinterface

// File: rtl/booth_sequencer.sv
// Control FSM for a radix-2 Booth multiplier datapath.
// Sequence: IDLE -> LOAD -> (ARITH -> SHIFT)* -> DONE -> IDLE.
// With FAST=1 every SHIFT skips the whole run of equal low-order multiplier
// bits, so runs of 0s/1s cost one ARITH/SHIFT pair instead of one per bit.
// The shift amount is worked out during ARITH (Q is stable across ARITH->SHIFT)
// and registered, so shmnt is a flop output; arithmetic is the only output
// that depends combinationally on Q.
module booth_sequencer #(
  parameter int NB   = 4,
  parameter bit FAST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_sequencer_if.slave   bus
);
  localparam int W = $clog2(NB) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARITH = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       state_r;
  logic [W-1:0] rem_r;        // unconsumed multiplier bits
  logic [W-1:0] op_count_r;
  logic [W-1:0] shmnt_r;
  logic         prev_r;       // last consumed multiplier bit (Booth q[-1])
  logic         load_r;
  logic         shift_r;
  logic         busy_r;
  logic         done_r;
  logic [W-1:0] k_s;          // shift amount for the upcoming SHIFT
  logic         arith_s;

  // Shift amount: first bit transition inside q[rem-1:0], or all of rem
  always_comb begin
    k_s = rem_r;
    if (FAST) begin
      // scanning downwards leaves the smallest qualifying j in k_s
      for (int j = NB - 1; j >= 1; j--) begin
        if ((W'(j) < rem_r) && (bus.q[j] != bus.q[j-1])) begin
          k_s = W'(j);
        end else begin
          k_s = k_s;
        end
      end
    end else begin
      k_s = W'(1);
    end
  end

  // Add/sub strobe in ARITH; in fast mode only when the Booth pair differs
  always_comb begin
    arith_s = 1'b0;
    if (state_r == S_ARITH) begin
      if (FAST) begin
        arith_s = (bus.q[0] != prev_r);
      end else begin
        arith_s = 1'b1;
      end
    end else begin
      arith_s = 1'b0;
    end
  end

  // Sequencer FSM with registered strobes and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      rem_r      <= {W{1'b0}};
      op_count_r <= {W{1'b0}};
      shmnt_r    <= {W{1'b0}};
      prev_r     <= 1'b0;
      load_r     <= 1'b0;
      shift_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r  <= 1'b0;
          shift_r <= 1'b0;
          shmnt_r <= {W{1'b0}};
          if (bus.start) begin
            state_r <= S_LOAD;
            load_r  <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        S_LOAD: begin
          load_r     <= 1'b0;
          rem_r      <= W'(NB);
          prev_r     <= 1'b0;
          op_count_r <= {W{1'b0}};
          state_r    <= S_ARITH;
        end
        S_ARITH: begin
          shift_r <= 1'b1;
          shmnt_r <= k_s;
          state_r <= S_SHIFT;
        end
        S_SHIFT: begin
          shift_r    <= 1'b0;
          shmnt_r    <= {W{1'b0}};
          // the skipped run equals q[0], so q[k-1] == q[0]
          prev_r     <= bus.q[0];
          rem_r      <= rem_r - shmnt_r;
          op_count_r <= op_count_r + W'(1);
          if (rem_r == shmnt_r) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_ARITH;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          load_r  <= 1'b0;
          shift_r <= 1'b0;
          shmnt_r <= {W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load       = load_r;
  assign bus.arithmetic = arith_s;
  assign bus.shift      = shift_r;
  assign bus.shmnt      = shmnt_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.op_count   = op_count_r;
endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: a FAST=1 and a FAST=0 instance, each paired with
// a behavioural Booth datapath. Expected results are queued at start and
// compared when done pulses.
module tb_booth_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_sequencer_if #(.NB(4)) bif_f ();
  booth_sequencer_if #(.NB(4)) bif_s ();

  booth_sequencer #(.NB(4), .FAST(1'b1)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bif_f));
  booth_sequencer #(.NB(4), .FAST(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bif_s));

  // Datapath state: A is one bit wider so -8 * -8 does not overflow
  typedef struct packed {
    logic [4:0] a;
    logic [3:0] q;
    logic       q1;
  } dp_t;

  dp_t        dp_f, dp_s;
  logic [3:0] m_r   [2];
  logic [3:0] qin_r [2];
  logic       start_r [2];

  function automatic dp_t dp_step(input dp_t s, input logic [3:0] m, input logic [3:0] qin,
                                  input logic ld, input logic ar, input logic sh,
                                  input logic [2:0] k);
    dp_t               n;
    logic [4:0]        mx;
    logic signed [9:0] cat;
    n  = s;
    mx = {m[3], m};
    if (ld) begin
      n.a  = 5'd0;
      n.q  = qin;
      n.q1 = 1'b0;
    end else if (ar) begin
      if (s.q[0] && !s.q1)      n.a = s.a - mx;
      else if (!s.q[0] && s.q1) n.a = s.a + mx;
    end else if (sh) begin
      cat = {s.a, s.q, s.q1};
      cat = cat >>> k;
      {n.a, n.q, n.q1} = cat;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    dp_f <= dp_step(dp_f, m_r[0], qin_r[0], bif_f.load, bif_f.arithmetic, bif_f.shift, bif_f.shmnt);
    dp_s <= dp_step(dp_s, m_r[1], qin_r[1], bif_s.load, bif_s.arithmetic, bif_s.shift, bif_s.shmnt);
  end

  assign bif_f.start = start_r[0];
  assign bif_s.start = start_r[1];
  assign bif_f.q     = dp_f.q;
  assign bif_s.q     = dp_s.q;

  // Per-instance views (index 0 = FAST, 1 = classic)
  logic       ld_v [2], ar_v [2], sh_v [2], bz_v [2], dn_v [2];
  logic [2:0] k_v [2], oc_v [2];
  logic [7:0] prod_v [2];
  assign ld_v[0] = bif_f.load;       assign ld_v[1] = bif_s.load;
  assign ar_v[0] = bif_f.arithmetic; assign ar_v[1] = bif_s.arithmetic;
  assign sh_v[0] = bif_f.shift;      assign sh_v[1] = bif_s.shift;
  assign bz_v[0] = bif_f.busy;       assign bz_v[1] = bif_s.busy;
  assign dn_v[0] = bif_f.done;       assign dn_v[1] = bif_s.done;
  assign k_v[0]  = bif_f.shmnt;      assign k_v[1]  = bif_s.shmnt;
  assign oc_v[0] = bif_f.op_count;   assign oc_v[1] = bif_s.op_count;
  assign prod_v[0] = {dp_f.a[3:0], dp_f.q};
  assign prod_v[1] = {dp_s.a[3:0], dp_s.q};

  typedef struct {
    logic [7:0] prod;
    int         ops;
    int         arith_n;
    bit         detail;
  } exp_t;

  exp_t sb_f[$];
  exp_t sb_s[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc [2]      = '{0, 0};
  int arith_n [2]  = '{0, 0};
  int sh_sum [2]   = '{0, 0};
  int load_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int excl_err [2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: strobe legality every cycle, scoreboard compare on done
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        cyc[d] = 0;
      end else begin
        if (ld_v[d]) begin
          cyc[d] = 1; arith_n[d] = 0; sh_sum[d] = 0; load_cnt[d]++;
        end else if (cyc[d] != 0) begin
          cyc[d]++;
        end
        if (ar_v[d]) arith_n[d]++;
        if (sh_v[d]) sh_sum[d] += int'(k_v[d]);
        if ((int'(ld_v[d]) + int'(ar_v[d]) + int'(sh_v[d])) > 1 ||
            (!sh_v[d] && k_v[d] != 3'd0) ||
            ((!bz_v[d] || dn_v[d]) && (ld_v[d] || ar_v[d] || sh_v[d])))
          excl_err[d]++;
        if (dn_v[d]) begin
          done_cnt[d]++;
          if ((d == 0 && sb_f.size() == 0) || (d == 1 && sb_s.size() == 0)) begin
            chk($sformatf("d%0d_unexpected_done", d), 1, 0);
          end else begin
            if (d == 0) mon_e = sb_f.pop_front();
            else        mon_e = sb_s.pop_front();
            chk($sformatf("d%0d_product", d), int'(prod_v[d]), int'(mon_e.prod));
            chk($sformatf("d%0d_shmnt_sum", d), sh_sum[d], 4);
            if (mon_e.detail) begin
              chk($sformatf("d%0d_op_count", d), int'(oc_v[d]), mon_e.ops);
              chk($sformatf("d%0d_latency", d), cyc[d], 2 * mon_e.ops + 2);
              chk($sformatf("d%0d_arith_cycles", d), arith_n[d], mon_e.arith_n);
            end
          end
          cyc[d] = 0;
        end
      end
    end
  end

  task automatic launch(input int d, input logic [3:0] m, input logic [3:0] q,
                        input int ops, input int an, input bit detail);
    exp_t e;
    int   mi, qi;
    mi = $signed(m);
    qi = $signed(q);
    e.prod    = 8'(mi * qi);
    e.ops     = ops;
    e.arith_n = an;
    e.detail  = detail;
    if (d == 0) begin
      m_r[0] = m; qin_r[0] = q; start_r[0] = 1'b1; sb_f.push_back(e);
    end else begin
      m_r[1] = m; qin_r[1] = q; start_r[1] = 1'b1; sb_s.push_back(e);
    end
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((sb_f.size() + sb_s.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_within_budget", int'(n < budget), 1);
    if (n >= budget) begin
      sb_f.delete();
      sb_s.delete();
    end
  endtask

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    int         ops;
    int         an;
  } vec_t;

  vec_t tbl [7];
  int   l0, d0;

  initial begin
    tbl = '{
      '{4'd3,    4'b0000, 1, 0},
      '{4'd3,    4'b0111, 2, 2},
      '{4'b1101, 4'b1000, 2, 1},
      '{4'd5,    4'b0101, 4, 4},
      '{4'd7,    4'b1111, 1, 1},
      '{4'd2,    4'b0110, 3, 2},
      '{4'b1000, 4'b1000, 2, 1}
    };
    rst_n = 1'b0;
    start_r = '{1'b0, 1'b0};
    m_r = '{4'd0, 4'd0};
    qin_r = '{4'd0, 4'd0};
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_strobes", d), int'({ld_v[d], ar_v[d], sh_v[d]}), 0);
      chk($sformatf("d%0d_rst_status", d), int'({bz_v[d], dn_v[d]}), 0);
      chk($sformatf("d%0d_rst_op_count", d), int'(oc_v[d]), 0);
      chk($sformatf("d%0d_rst_shmnt", d), int'(k_v[d]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run-skipping corner patterns
    for (int i = 0; i < 7; i++) begin
      launch(0, tbl[i].m, tbl[i].q, tbl[i].ops, tbl[i].an, 1'b1);
      pulse();
      wait_done(40);
    end

    // Exhaustive signed operands on both instances side by side
    for (int mi = -8; mi < 8; mi++) begin
      for (int qi = -8; qi < 8; qi++) begin
        launch(1, 4'(mi), 4'(qi), 4, 4, 1'b1);
        launch(0, 4'(mi), 4'(qi), 0, 0, 1'b0);
        pulse();
        wait_done(40);
      end
    end

    // Reset in the middle of a classic multiply
    launch(1, 4'd3, 4'd5, 4, 4, 1'b1);
    pulse();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", int'({bif_s.load, bif_s.arithmetic, bif_s.shift}), 0);
    chk("abort_busy_done", int'({bif_s.busy, bif_s.done}), 0);
    chk("abort_op_count", int'(bif_s.op_count), 0);
    sb_s.delete();
    d0 = done_cnt[1];
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt[1], d0);
    launch(1, 4'd6, 4'b1101, 4, 4, 1'b1);
    pulse();
    wait_done(40);

    // start held high across two complete multiplies
    l0 = load_cnt[0];
    d0 = done_cnt[0];
    launch(0, 4'd3, 4'b0000, 1, 0, 1'b1);
    launch(0, 4'd3, 4'b0000, 1, 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    wait_done(20);
    repeat (2) @(posedge clk);
    #1;
    chk("held_start_loads", load_cnt[0] - l0, 2);
    chk("held_start_dones", done_cnt[0] - d0, 2);
    chk("held_start_idle_busy", int'(bif_f.busy), 0);

    chk("fast_strobe_rules", excl_err[0], 0);
    chk("classic_strobe_rules", excl_err[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
